// File: rtl/multi_mesh_controller_if.sv
// Handshake and configuration bundle between the frame sequencer and its datapath.
interface multi_mesh_controller_if #(
    parameter int IDX_WIDTH = 2,
    parameter int WIDTH     = 32
);
    logic                 start;
    logic                 continuous;
    logic                 clear_en;

    logic                 cfg_we;
    logic [IDX_WIDTH-1:0] cfg_idx;
    logic [WIDTH-1:0]     cfg_base;
    logic [WIDTH-1:0]     cfg_count;
    logic                 cfg_strip;
    logic                 cfg_enable;

    logic                 mvp_pipe_start;
    logic                 mvp_pipe_update_mvp;
    logic                 mvp_pipe_done;
    logic [WIDTH-1:0]     mvp_pipe_base;
    logic [WIDTH-1:0]     mvp_pipe_count;

    logic                 draw_tri_pipe_start;
    logic                 draw_tri_pipe_done;
    logic [WIDTH-1:0]     draw_tri_pipe_count;
    logic                 draw_tri_pipe_strip;

    logic                 clear_start;
    logic                 clear_done;

    logic [IDX_WIDTH-1:0] mesh_index;
    logic                 busy;
    logic                 done;
    logic [15:0]          frame_count;

    modport master (
        input  start, continuous, clear_en,
        input  cfg_we, cfg_idx, cfg_base, cfg_count, cfg_strip, cfg_enable,
        input  mvp_pipe_done, draw_tri_pipe_done, clear_done,
        output mvp_pipe_start, mvp_pipe_update_mvp, mvp_pipe_base, mvp_pipe_count,
        output draw_tri_pipe_start, draw_tri_pipe_count, draw_tri_pipe_strip,
        output clear_start, mesh_index, busy, done, frame_count
    );

    modport slave (
        output start, continuous, clear_en,
        output cfg_we, cfg_idx, cfg_base, cfg_count, cfg_strip, cfg_enable,
        output mvp_pipe_done, draw_tri_pipe_done, clear_done,
        input  mvp_pipe_start, mvp_pipe_update_mvp, mvp_pipe_base, mvp_pipe_count,
        input  draw_tri_pipe_start, draw_tri_pipe_count, draw_tri_pipe_strip,
        input  clear_start, mesh_index, busy, done, frame_count
    );
endinterface

// File: rtl/multi_mesh_controller.sv
// Frame sequencer: optional clear, then transform + raster passes for each enabled mesh.
module multi_mesh_controller #(
    parameter int NUM_MESHES = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int WIDTH      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    multi_mesh_controller_if.master bus
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] CLEAR      = 4'd1;
    localparam logic [3:0] CLEAR_WAIT = 4'd2;
    localparam logic [3:0] SELECT     = 4'd3;
    localparam logic [3:0] MVP        = 4'd4;
    localparam logic [3:0] MVP_WAIT   = 4'd5;
    localparam logic [3:0] DRAW       = 4'd6;
    localparam logic [3:0] DRAW_WAIT  = 4'd7;
    localparam logic [3:0] NEXT       = 4'd8;
    localparam logic [3:0] FDONE      = 4'd9;

    logic [3:0]       state;
    logic [3:0]       state_nxt;

    logic [WIDTH-1:0] tbl_base   [NUM_MESHES];
    logic [WIDTH-1:0] tbl_count  [NUM_MESHES];
    logic             tbl_strip  [NUM_MESHES];
    logic             tbl_enable [NUM_MESHES];

    logic [WIDTH-1:0] sel_base;
    logic [WIDTH-1:0] sel_count;
    logic [WIDTH-1:0] sel_tri;
    logic             sel_strip;
    logic             sel_enable;
    logic             cfg_hit;
    logic             last_mesh;

    // Look up the entry at mesh_index and derive its triangle count
    always_comb begin
        sel_base   = tbl_base[bus.mesh_index];
        sel_count  = tbl_count[bus.mesh_index];
        sel_strip  = tbl_strip[bus.mesh_index];
        sel_enable = tbl_enable[bus.mesh_index];
        if (sel_strip) begin
            sel_tri = (sel_count >= WIDTH'(3)) ? sel_count - WIDTH'(2) : '0;
        end else begin
            sel_tri = sel_count / WIDTH'(3);
        end
        cfg_hit   = bus.cfg_we && (int'(bus.cfg_idx) < NUM_MESHES);
        last_mesh = (bus.mesh_index == IDX_WIDTH'(NUM_MESHES - 1));
    end

    // Mesh table: writable in any state, only sampled when a mesh is selected
    always_ff @(posedge clock) begin
        if (reset) begin
            tbl_base   <= '{default: '0};
            tbl_count  <= '{default: '0};
            tbl_strip  <= '{default: 1'b0};
            tbl_enable <= '{default: 1'b0};
        end else if (cfg_hit) begin
            tbl_base[bus.cfg_idx]   <= bus.cfg_base;
            tbl_count[bus.cfg_idx]  <= bus.cfg_count;
            tbl_strip[bus.cfg_idx]  <= bus.cfg_strip;
            tbl_enable[bus.cfg_idx] <= bus.cfg_enable;
        end
    end

    // Next-state decode; done inputs are only looked at in their own wait state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.start) state_nxt = bus.clear_en ? CLEAR : SELECT;
            CLEAR:      state_nxt = CLEAR_WAIT;
            CLEAR_WAIT: if (bus.clear_done) state_nxt = SELECT;
            SELECT:     state_nxt = (!sel_enable || sel_tri == '0) ? NEXT : MVP;
            MVP:        state_nxt = MVP_WAIT;
            MVP_WAIT:   if (bus.mvp_pipe_done) state_nxt = DRAW;
            DRAW:       state_nxt = DRAW_WAIT;
            DRAW_WAIT:  if (bus.draw_tri_pipe_done) state_nxt = NEXT;
            NEXT:       state_nxt = last_mesh ? FDONE : SELECT;
            FDONE: begin
                if (bus.continuous) state_nxt = bus.clear_en ? CLEAR : SELECT;
                else                state_nxt = IDLE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; pulses are decoded from the next state so they align with it
    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            bus.busy                <= 1'b0;
            bus.clear_start         <= 1'b0;
            bus.mvp_pipe_start      <= 1'b0;
            bus.mvp_pipe_update_mvp <= 1'b0;
            bus.draw_tri_pipe_start <= 1'b0;
            bus.done                <= 1'b0;
            bus.frame_count         <= '0;
            bus.mesh_index          <= '0;
            bus.mvp_pipe_base       <= '0;
            bus.mvp_pipe_count      <= '0;
            bus.draw_tri_pipe_count <= '0;
            bus.draw_tri_pipe_strip <= 1'b0;
        end else begin
            state                   <= state_nxt;
            bus.busy                <= (state_nxt != IDLE);
            bus.clear_start         <= (state_nxt == CLEAR);
            bus.mvp_pipe_start      <= (state_nxt == MVP);
            bus.mvp_pipe_update_mvp <= (state_nxt == MVP);
            bus.draw_tri_pipe_start <= (state_nxt == DRAW);
            bus.done                <= (state_nxt == FDONE);
            if (state_nxt == FDONE) begin
                bus.frame_count <= bus.frame_count + 16'd1;
            end
            if (state_nxt == SELECT) begin
                bus.mesh_index <= (state == NEXT) ? bus.mesh_index + IDX_WIDTH'(1) : '0;
            end
            if (state == SELECT) begin
                bus.mvp_pipe_base       <= sel_base;
                bus.mvp_pipe_count      <= sel_count;
                bus.draw_tri_pipe_count <= sel_tri;
                bus.draw_tri_pipe_strip <= sel_strip;
            end
        end
    end

endmodule

// File: tb/tb_multi_mesh_controller.sv
// Bench for multi_mesh_controller: directed scenarios plus randomized frames vs. a table model.
module tb_multi_mesh_controller;

    localparam int NM = 4;
    localparam int IW = 2;
    localparam int W  = 32;

    typedef struct {
        int unsigned  idx;
        logic [W-1:0] base;
        logic [W-1:0] count;
        logic [W-1:0] ntri;
        logic         strip;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        resp_mvp_done, resp_draw_done, resp_clear_done;
    logic        man_mvp_done, man_draw_done;
    bit          mvp_hold, draw_hold;
    int unsigned max_delay, clear_delay;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc = 0, n_clear = 0, n_done = 0, clear_done_cyc = 0;
    rec_t obs_mvp[$], obs_draw[$], exp_q[$];
    int   mvp_cyc_q[$];

    logic [W-1:0] m_base  [NM];
    logic [W-1:0] m_count [NM];
    bit           m_strip [NM];
    bit           m_en    [NM];
    int unsigned  fc_exp;

    always #5 clock = ~clock;

    multi_mesh_controller_if #(.IDX_WIDTH(IW), .WIDTH(W)) bus ();

    multi_mesh_controller #(.NUM_MESHES(NM), .IDX_WIDTH(IW), .WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mvp_pipe_done      = resp_mvp_done | man_mvp_done;
    assign bus.draw_tri_pipe_done = resp_draw_done | man_draw_done;
    assign bus.clear_done         = resp_clear_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] tri_count(input logic [W-1:0] c, input bit s);
        if (s) return (c >= 3) ? c - 2 : '0;
        return c / 3;
    endfunction

    function automatic void model_clear();
        for (int unsigned i = 0; i < NM; i++) begin
            m_base[i] = '0; m_count[i] = '0; m_strip[i] = 1'b0; m_en[i] = 1'b0;
        end
        fc_exp = 0;
    endfunction

    function automatic void build_expected();
        rec_t r;
        exp_q.delete();
        for (int unsigned i = 0; i < NM; i++) begin
            if (m_en[i] && tri_count(m_count[i], m_strip[i]) != 0) begin
                r.idx = i; r.base = m_base[i]; r.count = m_count[i];
                r.ntri = tri_count(m_count[i], m_strip[i]); r.strip = m_strip[i];
                exp_q.push_back(r);
            end
        end
    endfunction

    // Observe pulses on the falling edge, away from the active edge
    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clock);
            cyc++;
            if (bus.mvp_pipe_start)      check("update_with_start", bus.mvp_pipe_update_mvp, 1);
            if (bus.mvp_pipe_update_mvp) check("start_with_update", bus.mvp_pipe_start, 1);
            r.idx   = 32'(bus.mesh_index);
            r.base  = bus.mvp_pipe_base;
            r.count = bus.mvp_pipe_count;
            r.ntri  = bus.draw_tri_pipe_count;
            r.strip = bus.draw_tri_pipe_strip;
            if (bus.mvp_pipe_start) begin
                obs_mvp.push_back(r);
                mvp_cyc_q.push_back(cyc);
            end
            if (bus.draw_tri_pipe_start) obs_draw.push_back(r);
            if (bus.clear_start) n_clear++;
            if (bus.clear_done)  clear_done_cyc = cyc;
            if (bus.done)        n_done++;
        end
    end

    initial begin : mvp_responder
        int unsigned d;
        resp_mvp_done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.mvp_pipe_start && !mvp_hold) begin
                d = $urandom_range(0, max_delay);
                @(posedge clock); #1;
                repeat (d) begin @(posedge clock); #1; end
                resp_mvp_done = 1'b1;
                @(posedge clock); #1;
                resp_mvp_done = 1'b0;
            end
        end
    end

    initial begin : draw_responder
        int unsigned d;
        resp_draw_done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.draw_tri_pipe_start && !draw_hold) begin
                d = $urandom_range(0, max_delay);
                @(posedge clock); #1;
                repeat (d) begin @(posedge clock); #1; end
                resp_draw_done = 1'b1;
                @(posedge clock); #1;
                resp_draw_done = 1'b0;
            end
        end
    end

    initial begin : clear_responder
        resp_clear_done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.clear_start) begin
                @(posedge clock); #1;
                repeat (clear_delay) begin @(posedge clock); #1; end
                resp_clear_done = 1'b1;
                @(posedge clock); #1;
                resp_clear_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "time limit");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},        bus.busy, 0);
        check({tag, "_mesh_index"},  bus.mesh_index, 0);
        check({tag, "_frame_count"}, bus.frame_count, 0);
        check({tag, "_mvp_base"},    bus.mvp_pipe_base, 0);
        check({tag, "_mvp_count"},   bus.mvp_pipe_count, 0);
        check({tag, "_draw_count"},  bus.draw_tri_pipe_count, 0);
        check({tag, "_draw_strip"},  bus.draw_tri_pipe_strip, 0);
        check({tag, "_pulses"},      {bus.clear_start, bus.mvp_pipe_start, bus.mvp_pipe_update_mvp,
                                      bus.draw_tri_pipe_start, bus.done}, 0);
    endtask

    task automatic do_reset();
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        model_clear();
    endtask

    task automatic cfg_write(input int unsigned idx, input logic [W-1:0] base,
                             input logic [W-1:0] count, input bit strip, input bit en);
        @(posedge clock); #1;
        bus.cfg_we = 1'b1; bus.cfg_idx = IW'(idx); bus.cfg_base = base;
        bus.cfg_count = count; bus.cfg_strip = strip; bus.cfg_enable = en;
        @(posedge clock); #1;
        bus.cfg_we = 1'b0;
        if (idx < NM) begin
            m_base[idx] = base; m_count[idx] = count; m_strip[idx] = strip; m_en[idx] = en;
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clock);
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_done_pulse"}, seen, 1);
        fc_exp = (fc_exp + 1) & 32'hFFFF;
    endtask

    task automatic compare_records(input string tag);
        check({tag, "_n_mvp"},  obs_mvp.size(),  exp_q.size());
        check({tag, "_n_draw"}, obs_draw.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < obs_mvp.size()) begin
                check({tag, "_mvp_idx"},   obs_mvp[i].idx,   exp_q[i].idx);
                check({tag, "_mvp_base"},  obs_mvp[i].base,  exp_q[i].base);
                check({tag, "_mvp_count"}, obs_mvp[i].count, exp_q[i].count);
            end
            if (i < obs_draw.size()) begin
                check({tag, "_draw_idx"},   obs_draw[i].idx,   exp_q[i].idx);
                check({tag, "_draw_tri"},   obs_draw[i].ntri,  exp_q[i].ntri);
                check({tag, "_draw_strip"}, obs_draw[i].strip, exp_q[i].strip);
                check({tag, "_held_base"},  obs_draw[i].base,  exp_q[i].base);
                check({tag, "_held_count"}, obs_draw[i].count, exp_q[i].count);
            end
        end
    endtask

    task automatic run_frame(input bit ce, input string tag);
        build_expected();
        obs_mvp.delete(); obs_draw.delete(); mvp_cyc_q.delete();
        @(posedge clock); #1;
        bus.clear_en = ce; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        wait_done(tag);
        @(negedge clock);
        check({tag, "_idle"}, bus.busy, 0);
        check({tag, "_frame_count"}, bus.frame_count, fc_exp);
        compare_records(tag);
    endtask

    initial begin : main
        int n, k, n_clear_base, n_done_base;
        bit seen;
        reset = 1'b1;
        bus.start = 1'b0; bus.continuous = 1'b0; bus.clear_en = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_base = '0; bus.cfg_count = '0;
        bus.cfg_strip = 1'b0; bus.cfg_enable = 1'b0;
        man_mvp_done = 1'b0; man_draw_done = 1'b0;
        mvp_hold = 1'b0; draw_hold = 1'b0; max_delay = 3; clear_delay = 2;
        model_clear();
        repeat (2) @(posedge clock);
        #1; reset = 1'b0;
        check_reset_values("por");

        // single strip mesh
        cfg_write(0, 32'h0, 4, 1'b1, 1'b1);
        run_frame(1'b0, "single");

        // lists on 0 and 2, disabled 1, degenerate strip on 3
        do_reset();
        cfg_write(0, 32'h100, 6, 1'b0, 1'b1);
        cfg_write(1, 32'h200, 6, 1'b0, 1'b0);
        cfg_write(2, 32'h300, 9, 1'b0, 1'b1);
        cfg_write(3, 32'h400, 2, 1'b1, 1'b1);
        run_frame(1'b0, "mixed");

        // minimum frame length with nothing enabled
        do_reset();
        bus.clear_en = 1'b0;
        check("min_busy_before", bus.busy, 0);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("min_busy_after", bus.busy, 1);
        n = 1;
        while (!bus.done && n < 100) begin @(posedge clock); #1; n++; end
        check("min_frame_cycles", n, 2 * NM + 1);
        fc_exp++;
        @(posedge clock); #1;
        check("min_frame_count", bus.frame_count, fc_exp);
        check("min_idle", bus.busy, 0);

        // slow clear engine
        do_reset();
        cfg_write(0, 32'h40, 3, 1'b0, 1'b1);
        clear_delay = 10;
        n_clear_base = n_clear;
        run_frame(1'b1, "clr");
        check("clr_pulses", n_clear - n_clear_base, 1);
        if (mvp_cyc_q.size() > 0) check("clr_to_mvp", mvp_cyc_q[0] - clear_done_cyc, 2);
        clear_delay = 2;

        // three back-to-back frames
        do_reset();
        cfg_write(1, 32'h80, 5, 1'b1, 1'b1);
        obs_draw.delete();
        n_clear_base = n_clear; n_done_base = n_done;
        @(posedge clock); #1;
        bus.continuous = 1'b1; bus.clear_en = 1'b1; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        k = 0;
        for (int i = 0; i < 3000 && k < 3; i++) begin
            @(negedge clock);
            if (bus.done) begin
                k++;
                if (k == 3) bus.continuous = 1'b0;
            end
        end
        check("cont_frames", k, 3);
        @(negedge clock);
        check("cont_idle", bus.busy, 0);
        check("cont_frame_count", bus.frame_count, 3);
        check("cont_draws", obs_draw.size(), 3);
        check("cont_clears", n_clear - n_clear_base, 3);
        check("cont_done_pulses", n_done - n_done_base, 3);
        bus.clear_en = 1'b0;

        // stray raster done in MVP_WAIT, then reset mid-frame
        do_reset();
        cfg_write(0, 32'h10, 3, 1'b0, 1'b1);
        mvp_hold = 1'b1;
        obs_mvp.delete(); obs_draw.delete(); n_done_base = n_done;
        @(posedge clock); #1; bus.start = 1'b1;
        @(posedge clock); #1; bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            if (bus.mvp_pipe_start) seen = 1'b1;
        end
        check("hold_mvp_seen", seen, 1);
        @(posedge clock); #1; man_draw_done = 1'b1;
        @(posedge clock); #1; man_draw_done = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("stray_busy", bus.busy, 1);
        check("stray_no_draw", obs_draw.size(), 0);
        check("stray_no_done", n_done - n_done_base, 0);
        check("stray_index", bus.mesh_index, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear();
        check_reset_values("mid_reset");
        man_mvp_done = 1'b1;
        @(posedge clock); #1;
        man_mvp_done = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("late_done_busy", bus.busy, 0);
        check("late_done_no_draw", obs_draw.size(), 0);
        check("late_done_no_mvp", obs_mvp.size(), 1);
        check("late_done_no_frame", n_done - n_done_base, 0);
        mvp_hold = 1'b0;
        run_frame(1'b0, "post_reset");

        // table write to the current mesh while it is being drawn
        do_reset();
        cfg_write(0, 32'h500, 6, 1'b0, 1'b1);
        draw_hold = 1'b1;
        @(posedge clock); #1; bus.start = 1'b1;
        @(posedge clock); #1; bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (bus.draw_tri_pipe_start) seen = 1'b1;
        end
        check("hold_draw_seen", seen, 1);
        cfg_write(0, 32'h600, 9, 1'b0, 1'b1);
        @(posedge clock); #1;
        check("cfgwr_draw_count", bus.draw_tri_pipe_count, 2);
        check("cfgwr_mvp_count", bus.mvp_pipe_count, 6);
        check("cfgwr_mvp_base", bus.mvp_pipe_base, 32'h500);
        check("cfgwr_busy", bus.busy, 1);
        man_draw_done = 1'b1;
        @(posedge clock); #1;
        man_draw_done = 1'b0;
        draw_hold = 1'b0;
        wait_done("cfgwr");
        run_frame(1'b0, "cfgwr_next");

        // randomized tables, modes and response latencies
        for (int f = 0; f < 24; f++) begin
            for (int unsigned i = 0; i < NM; i++) begin
                cfg_write(i, $urandom, $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
            end
            max_delay   = $urandom_range(0, 5);
            clear_delay = $urandom_range(0, 5);
            run_frame(1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_mesh_controller.md
# multi_mesh_controller

Parametrised successor to the single-mesh pipe controller. Sequences a frame over up to NUM_MESHES meshes: optional screen clear, then for each enabled mesh a transform pass through mvp_pipe followed by a raster pass through draw_triangle_pipe. Each mesh's base address, vertex count and strip/list mode come from an internal mesh table. Continuous mode loops frames back-to-back. The block sits between the top-level start/flight logic and the mvp_pipe / draw_triangle_pipe / screen_writer datapath.

## Interface
- NUM_MESHES, 4: mesh table entries (1..16)
- IDX_WIDTH, 2: width of mesh index; must be ≥ clog2(NUM_MESHES), and ≥ 1
- WIDTH, 32: address / count width
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; clears state, table and outputs
- start  in  1  frame request; sampled in IDLE only
- continuous  in  1  1 = start next frame immediately after done
- clear_en  in  1  1 = run clear phase at frame start
- cfg_we  in  1  mesh table write strobe
- cfg_idx  in  IDX_WIDTH  table entry written; writes with cfg_idx ≥ NUM_MESHES are ignored
- cfg_base  in  WIDTH  mesh vertex base address
- cfg_count  in  WIDTH  vertex count
- cfg_strip  in  1  1 = triangle strip, 0 = triangle list
- cfg_enable  in  1  entry enable
- mvp_pipe_start, mvp_pipe_update_mvp  out  1  one-cycle pulses, always coincident
- mvp_pipe_done  in  1  transform pass complete (pulse)
- mvp_pipe_base, mvp_pipe_count  out  WIDTH  base / vertex count of current mesh
- draw_tri_pipe_start  out  1  one-cycle pulse
- draw_tri_pipe_done  in  1  raster pass complete (pulse)
- draw_tri_pipe_count  out  WIDTH  triangle count of current mesh
- draw_tri_pipe_strip  out  1  mode of current mesh
- clear_start  out  1  one-cycle pulse to the screen clear engine
- clear_done  in  1  clear complete (pulse)
- mesh_index  out  IDX_WIDTH  current mesh; drives the external pose mux
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of each frame
- frame_count  out  16  completed frames, wraps 0xFFFF→0

## Operation
- Table entry reset value: base=0, count=0, strip=0, enable=0. Writes are accepted in any state. A write takes effect for a mesh only when that mesh is next latched in SELECT; the current mesh's latched values are unaffected.
- Triangle count: strip → count−2 if count ≥ 3, else 0; list → count/3 (floor).
- States:
  - IDLE: start=1 → CLEAR if clear_en, else SELECT with mesh_index=0.
  - CLEAR: pulse clear_start → CLEAR_WAIT.
  - CLEAR_WAIT: clear_done → SELECT, mesh_index=0.
  - SELECT: latch the entry into the output registers. If enable=0 or the triangle count is 0 → NEXT (skipped); else → MVP.
  - MVP: pulse mvp_pipe_start + update_mvp → MVP_WAIT.
  - MVP_WAIT: mvp_pipe_done → DRAW.
  - DRAW: pulse draw_tri_pipe_start → DRAW_WAIT.
  - DRAW_WAIT: draw_tri_pipe_done → NEXT.
  - NEXT: if mesh_index = NUM_MESHES−1 → FDONE; else increment mesh_index → SELECT.
  - FDONE: pulse done, increment frame_count. If continuous=1 → CLEAR (clear_en=1) or SELECT with index 0; else → IDLE.
- Done inputs arriving in any state other than their matching WAIT state are ignored.
- start while busy is ignored.
- A frame with no drawable mesh still completes and pulses done.

## Timing
- Reset values: all pulse outputs 0; busy=0; mesh_index=0; frame_count=0; mvp_pipe_base, mvp_pipe_count, draw_tri_pipe_count and draw_tri_pipe_strip all 0; state IDLE.
- All outputs are registered. start sampled at edge t gives busy=1 from t+1.
- clear_start is high for exactly the cycle in the CLEAR state. The same one-cycle rule applies to mvp_pipe_start in MVP, draw_tri_pipe_start in DRAW, and done in FDONE.
- Latched mesh outputs are valid from the cycle after SELECT. They are stable through the end of DRAW_WAIT.
- A skipped mesh costs 2 cycles (SELECT, NEXT).
- Minimum frame with clear_en=0 and all meshes disabled: 2·NUM_MESHES+1 cycles from IDLE exit to the done pulse.
- A done input in the same cycle the WAIT state is entered is accepted.
- Reset mid-frame: the next cycle is IDLE with reset values and the table is cleared. No further pulses are issued.

## Test plan
- Reset, write mesh0 = {base=0, count=4, strip=1, en=1}, start, clear_en=0 → one mvp_pipe_start with base=0, count=4; then draw_tri_pipe_count=2, strip=1; one done pulse; frame_count=1.
- Meshes 0 and 2 enabled as lists (count 6, count 9), mesh 1 disabled, mesh 3 with count=2 strip → draws issued only for index 0 (count 2) and index 2 (count 3), then done.
- clear_en=1 with clear_done delayed 10 cycles → no mvp_pipe_start until the cycle after clear_done + SELECT.
- continuous=1 for 3 frames, then 0 → 3 done pulses, frame_count=3, busy=0 after the last one.
- Reset asserted during MVP_WAIT → next cycle busy=0 and all outputs at reset values; a late mvp_pipe_done is ignored.
- A stray draw_tri_pipe_done during MVP_WAIT → no state change. A cfg write to the current mesh during DRAW_WAIT → draw_tri_pipe_count unchanged until the next frame.
